// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, sign-corrected on the final cycle, fixed 33-cycle latency.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, stateNext;

  logic [2:0]        opFunct3;
  logic              signA, signB, divZero, divOverflow;
  logic [XLEN-1:0]   absA, absB;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  counter;

  logic              aSignedOp, bSignedOp, inSignA, inSignB;
  logic [XLEN-1:0]   inAbsA, inAbsB;
  logic              inDivZero, inOverflow;

  logic [XLEN:0]     mulSum, remShift;
  logic              remFits;
  logic [XLEN-1:0]   remNext;

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quo, finalResult;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (counter == CNT_W'(XLEN-1)) stateNext = FIN;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand decode at acceptance: which operands are signed and their magnitudes.
  always_comb begin
    aSignedOp = 1'b0;
    bSignedOp = 1'b0;
    case (funct3)
      F_MUL, F_MULH, F_DIV, F_REM: begin
        aSignedOp = 1'b1;
        bSignedOp = 1'b1;
      end
      F_MULHSU: aSignedOp = 1'b1;
      default: ;
    endcase
    inSignA    = aSignedOp & operandA[XLEN-1];
    inSignB    = bSignedOp & operandB[XLEN-1];
    inAbsA     = inSignA ? -operandA : operandA;
    inAbsB     = inSignB ? -operandB : operandB;
    inDivZero  = (operandB == '0);
    inOverflow = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                 (operandA == MIN_INT) && (operandB == '1);
  end

  // One iteration: the low half of acc holds the multiplier (mul) or the
  // dividend being shifted out / quotient being shifted in (div).
  always_comb begin
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, absA} : '0);
    remShift = {rem, acc[XLEN-1]};
    remFits  = (remShift >= {1'b0, absB});
    remNext  = remFits ? XLEN'(remShift - {1'b0, absB}) : remShift[XLEN-1:0];
  end

  always_comb begin
    product     = (signA ^ signB) ? -acc : acc;
    quo         = acc[XLEN-1:0];
    finalResult = '0;
    case (opFunct3)
      F_MUL:                     finalResult = product[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: finalResult = product[2*XLEN-1:XLEN];
      F_DIV:    finalResult = divZero ? '1 : divOverflow ? MIN_INT :
                              (signA ^ signB) ? -quo : quo;
      F_DIVU:   finalResult = divZero ? '1 : quo;
      F_REM:    finalResult = divZero ? (signA ? -absA : absA) :
                              divOverflow ? '0 : signA ? -rem : rem;
      F_REMU:   finalResult = divZero ? absA : rem;
      default:  finalResult = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opFunct3    <= '0;
      signA       <= 1'b0;
      signB       <= 1'b0;
      divZero     <= 1'b0;
      divOverflow <= 1'b0;
      absA        <= '0;
      absB        <= '0;
      acc         <= '0;
      rem         <= '0;
      counter     <= '0;
      result      <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            opFunct3    <= funct3;
            signA       <= inSignA;
            signB       <= inSignB;
            divZero     <= inDivZero;
            divOverflow <= inOverflow;
            absA        <= inAbsA;
            absB        <= inAbsB;
            rem         <= '0;
            counter     <= '0;
            acc         <= {{XLEN{1'b0}}, (funct3[2] ? inAbsA : inAbsB)};
          end
        end
        CALC: begin
          counter <= counter + CNT_W'(1);
          if (opFunct3[2]) begin
            rem             <= remNext;
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], remFits};
          end else begin
            acc <= {mulSum, acc[XLEN-1:1]};
          end
        end
        FIN:     result <= finalResult;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: a cycle-level reference built on plain integer
// arithmetic is checked against the DUT every cycle, plus directed literal cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .operandA(operandA), .operandB(operandB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference result straight from the RV32M definitions.
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  // Cycle-level model: an accepted request completes exactly 33 edges later.
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mResult = '0;
  logic [31:0] mPending = '0;
  int          mRemaining = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mResult <= '0;
      mRemaining <= 0;
    end else begin
      mDone <= (mRemaining == 1);
      if (mRemaining == 1) begin
        mResult <= mPending;
        mBusy <= 1'b0;
        mRemaining <= 0;
      end else if (mRemaining > 1) begin
        mRemaining <= mRemaining - 1;
      end else if (start) begin
        mPending <= refResult(funct3, operandA, operandB);
        mRemaining <= 33;
        mBusy <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("result", result, mResult);
  end

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Present a request for one cycle, then scramble the inputs.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    funct3 = f;
    operandA = a;
    operandB = b;
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    operandA = $urandom;
    operandB = $urandom;
  endtask

  task automatic waitDone(input string name, input int startCycles, input logic [31:0] expected);
    int cycles;
    cycles = startCycles;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, "_latency"}, 32'(cycles), 32'd33);
    checkOutput(name, result, expected);
  endtask

  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(f, a, b);
    waitDone(name, 0, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int doneSeen;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);

    checkOutput("model_mulhsu", refResult(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    checkOutput("model_rem_neg", refResult(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    runOp("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(negedge clk);
    checkOutput("done_dropped", 32'(done), 32'd0);
    checkOutput("result_held", result, 32'hFFFF_FFEB);

    runOp("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runOp("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runOp("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
    runOp("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);
    runOp("div_by_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runOp("remu_by_zero", 3'b111, 32'd13, 32'd0, 32'd13);
    runOp("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    applyStimulus(3'b101, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; operandA = 32'd3; operandB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone("divu_ignores_start", 10, 32'd14);
    runOp("mul_in_done_cycle", 3'b000, 32'd3, 32'd3, 32'd9);

    applyStimulus(3'b000, 32'd5, 32'd5);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_done", 32'(done), 32'd0);
    checkOutput("async_reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("no_done_after_reset", 32'(doneSeen), 32'd0);
    runOp("mulhu_after_reset", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0,
          refResult(3'b011, 32'h1234_5678, 32'h9ABC_DEF0));

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      funct3 = 3'($urandom_range(0, 7));
      operandA = pickOperand();
      operandB = pickOperand();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
